// File: rtl/issue_queue_if.sv
// Dispatch, CDB wakeup and issue handshake bundle for issue_queue.
// master drives dispatch/CDB/iss_ready; slave is the queue itself.
interface issue_queue_if #(
  parameter int unsigned TAG_W = 3
);
  logic             disp_valid;
  logic             disp_ready;
  logic [7:0]       disp_instr;
  logic [TAG_W-1:0] disp_src1_tag;
  logic [TAG_W-1:0] disp_src2_tag;
  logic             disp_src1_rdy;
  logic             disp_src2_rdy;
  logic [7:0]       disp_src1_val;
  logic [7:0]       disp_src2_val;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [7:0]       cdb_data;

  logic             iss_valid;
  logic             iss_ready;
  logic [7:0]       iss_instr;
  logic [7:0]       iss_rd1;
  logic [7:0]       iss_rd2;

  modport master (
    output disp_valid, disp_instr, disp_src1_tag, disp_src2_tag,
           disp_src1_rdy, disp_src2_rdy, disp_src1_val, disp_src2_val,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  disp_ready, iss_valid, iss_instr, iss_rd1, iss_rd2
  );

  modport slave (
    input  disp_valid, disp_instr, disp_src1_tag, disp_src2_tag,
           disp_src1_rdy, disp_src2_rdy, disp_src1_val, disp_src2_val,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    output disp_ready, iss_valid, iss_instr, iss_rd1, iss_rd2
  );
endinterface

// File: rtl/issue_queue.sv
// Collapsing, age-ordered issue queue with CDB wakeup and oldest-ready select.
// Optional issue-stall counter enabled by defining ISSUE_QUEUE_STALL_CNT_EN.
module issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  issue_queue_if.slave       bus,
  output logic [3:0]         occupancy,
  output logic [7:0]         stall_cnt
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] instr;
    logic              rdy1;
    logic              rdy2;
    logic [TAG_W-1:0]  tag1;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           ent_w [DEPTH];
  entry_t           new_ent;
  entry_t           sel_ent;
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;
  logic [CNT_W-1:0] occ_base;
  logic [IDX_W-1:0] sel_idx;
  logic             any_iss;
  logic             iss_fire;
  logic             disp_fire;

  // Oldest issuable entry wins; scan from youngest so the lowest index lands last.
  always_comb begin
    any_iss = 1'b0;
    sel_idx = '0;
    sel_ent = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
        any_iss = 1'b1;
        sel_idx = IDX_W'(i);
        sel_ent = ent_q[i];
      end
    end
  end

  assign bus.iss_valid  = any_iss && !flush;
  assign bus.iss_instr  = bus.iss_valid ? sel_ent.instr : 8'h00;
  assign bus.iss_rd1    = bus.iss_valid ? sel_ent.val1  : 8'h00;
  assign bus.iss_rd2    = bus.iss_valid ? sel_ent.val2  : 8'h00;
  assign bus.disp_ready = (occ_q < CNT_W'(DEPTH)) && !flush;
  assign occupancy      = occ_q;

  assign iss_fire  = bus.iss_valid && bus.iss_ready;
  assign disp_fire = bus.disp_valid && bus.disp_ready;

  // Wakeup of resident entries; takes effect at the edge, never bypassed to select.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = ent_q[i];
      if (bus.cdb_valid && ent_q[i].valid) begin
        if (!ent_q[i].rdy1 && (ent_q[i].tag1 == bus.cdb_tag)) begin
          ent_w[i].rdy1 = 1'b1;
          ent_w[i].val1 = bus.cdb_data;
        end
        if (!ent_q[i].rdy2 && (ent_q[i].tag2 == bus.cdb_tag)) begin
          ent_w[i].rdy2 = 1'b1;
          ent_w[i].val2 = bus.cdb_data;
        end
      end
    end
  end

  // Incoming entry, including a wakeup that coincides with its dispatch.
  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.instr = bus.disp_instr;
    new_ent.tag1  = bus.disp_src1_tag;
    new_ent.tag2  = bus.disp_src2_tag;
    new_ent.rdy1  = bus.disp_src1_rdy;
    new_ent.rdy2  = bus.disp_src2_rdy;
    new_ent.val1  = bus.disp_src1_val;
    new_ent.val2  = bus.disp_src2_val;
    if (bus.cdb_valid && !bus.disp_src1_rdy && (bus.disp_src1_tag == bus.cdb_tag)) begin
      new_ent.rdy1 = 1'b1;
      new_ent.val1 = bus.cdb_data;
    end
    if (bus.cdb_valid && !bus.disp_src2_rdy && (bus.disp_src2_tag == bus.cdb_tag)) begin
      new_ent.rdy2 = 1'b1;
      new_ent.val2 = bus.cdb_data;
    end
  end

  // Collapse on issue first, then append at the post-removal tail; flush overrides all.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_w[i];
    end
    if (iss_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          ent_d[i] = ent_w[i + 1];
        end
      end
      ent_d[DEPTH - 1] = '0;
    end
    occ_base = occ_q - CNT_W'(iss_fire);
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == occ_base) begin
          ent_d[i] = new_ent;
        end
      end
    end
    occ_d = occ_base + CNT_W'(disp_fire);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = '0;
      end
      occ_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

`ifdef ISSUE_QUEUE_STALL_CNT_EN
  logic [7:0] stall_q;
  logic [7:0] stall_d;

  // Saturating count of cycles an offered entry is refused; flush does not clear it.
  always_comb begin
    stall_d = stall_q;
    if (bus.iss_valid && !bus.iss_ready && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 8'h00;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: vector table, corner-case sequences
// and a scoreboard-driven random stream of ready instructions.
module tb_issue_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 3;
`ifdef ISSUE_QUEUE_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] occupancy;
  logic [7:0] stall_cnt;

  int total = 0;
  int bad = 0;
  int exp_stall = 0;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] rd1;
    logic [7:0] rd2;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       dv;
    logic [7:0] instr;
    logic [2:0] t1;
    logic [2:0] t2;
    logic       r1;
    logic       r2;
    logic [7:0] v1;
    logic [7:0] v2;
    logic       cv;
    logic [2:0] ct;
    logic [7:0] cd;
    logic       ir;
    logic       e_iv;
    logic [7:0] e_in;
    logic [7:0] e_r1;
    logic [7:0] e_r2;
    logic [3:0] e_occ;
    logic       e_dr;
  } vec_t;
  vec_t vt[20];

  issue_queue_if #(.TAG_W(TAG_W)) bus ();

  issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_sc();
    return STALL_EN ? exp_stall : 0;
  endfunction

  task automatic add_stall();
    if (exp_stall < 255) exp_stall++;
  endtask

  task automatic idle();
    bus.disp_valid    = 1'b0;
    bus.disp_instr    = 8'h00;
    bus.disp_src1_tag = 3'd0;
    bus.disp_src2_tag = 3'd0;
    bus.disp_src1_rdy = 1'b0;
    bus.disp_src2_rdy = 1'b0;
    bus.disp_src1_val = 8'h00;
    bus.disp_src2_val = 8'h00;
    bus.cdb_valid     = 1'b0;
    bus.cdb_tag       = 3'd0;
    bus.cdb_data      = 8'h00;
    bus.iss_ready     = 1'b0;
    flush             = 1'b0;
  endtask

  task automatic disp(input logic [7:0] ins, input logic [2:0] t1, input logic [2:0] t2,
                      input logic r1, input logic r2, input logic [7:0] v1, input logic [7:0] v2);
    bus.disp_valid    = 1'b1;
    bus.disp_instr    = ins;
    bus.disp_src1_tag = t1;
    bus.disp_src2_tag = t2;
    bus.disp_src1_rdy = r1;
    bus.disp_src2_rdy = r2;
    bus.disp_src1_val = v1;
    bus.disp_src2_val = v2;
  endtask

  task automatic cdb(input logic [2:0] t, input logic [7:0] d);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = t;
    bus.cdb_data  = d;
  endtask

  function automatic vec_t mk(input logic dv, input logic [7:0] ins, input logic [2:0] t1,
                              input logic [2:0] t2, input logic r1, input logic r2,
                              input logic [7:0] v1, input logic [7:0] v2, input logic cv,
                              input logic [2:0] ct, input logic [7:0] cd, input logic ir,
                              input logic eiv, input logic [7:0] ein, input logic [7:0] er1,
                              input logic [7:0] er2, input logic [3:0] eocc, input logic edr);
    vec_t v;
    v.dv = dv; v.instr = ins; v.t1 = t1; v.t2 = t2; v.r1 = r1; v.r2 = r2;
    v.v1 = v1; v.v2 = v2; v.cv = cv; v.ct = ct; v.cd = cd; v.ir = ir;
    v.e_iv = eiv; v.e_in = ein; v.e_r1 = er1; v.e_r2 = er2; v.e_occ = eocc; v.e_dr = edr;
    return v;
  endfunction

  // Pops the scoreboard as the DUT issues; all remaining entries must already be ready.
  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk); idle(); bus.iss_ready = 1'b1; #1;
      chk({name, " occ"}, 32'(occupancy), 32'(sb.size()));
      chk({name, " iss_valid"}, 32'(bus.iss_valid), 32'd1);
      chk({name, " iss_instr"}, 32'(bus.iss_instr), 32'(sb[0].instr));
      chk({name, " iss_rd1"}, 32'(bus.iss_rd1), 32'(sb[0].rd1));
      chk({name, " iss_rd2"}, 32'(bus.iss_rd2), 32'(sb[0].rd2));
      void'(sb.pop_front());
      n++;
    end
    chk({name, " drained"}, 32'(sb.size()), 32'd0);
    @(negedge clk); idle(); #1;
    chk({name, " occ_end"}, 32'(occupancy), 32'd0);
  endtask

  initial begin
    logic       dv;
    logic       ir;
    logic [7:0] ins;
    logic [7:0] a;
    logic [7:0] b;
    int         sz;

    vt[0]  = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b0,3'd0,8'h00,1'b0, 1'b0,8'h00,8'h00,8'h00,4'd0,1'b1);
    vt[1]  = mk(1'b1,8'h01,3'd0,3'd0,1'b1,1'b1,8'h05,8'h03, 1'b0,3'd0,8'h00,1'b1, 1'b0,8'h00,8'h00,8'h00,4'd0,1'b1);
    vt[2]  = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b0,3'd0,8'h00,1'b1, 1'b1,8'h01,8'h05,8'h03,4'd1,1'b1);
    vt[3]  = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b0,3'd0,8'h00,1'b0, 1'b0,8'h00,8'h00,8'h00,4'd0,1'b1);
    vt[4]  = mk(1'b1,8'h11,3'd5,3'd0,1'b0,1'b1,8'h00,8'h22, 1'b1,3'd5,8'h7F,1'b1, 1'b0,8'h00,8'h00,8'h00,4'd0,1'b1);
    vt[5]  = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b0,3'd0,8'h00,1'b1, 1'b1,8'h11,8'h7F,8'h22,4'd1,1'b1);
    vt[6]  = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b0,3'd0,8'h00,1'b0, 1'b0,8'h00,8'h00,8'h00,4'd0,1'b1);
    vt[7]  = mk(1'b1,8'hA0,3'd3,3'd0,1'b0,1'b1,8'h00,8'h0B, 1'b0,3'd0,8'h00,1'b1, 1'b0,8'h00,8'h00,8'h00,4'd0,1'b1);
    vt[8]  = mk(1'b1,8'hB0,3'd0,3'd0,1'b1,1'b1,8'h01,8'h02, 1'b0,3'd0,8'h00,1'b1, 1'b0,8'h00,8'h00,8'h00,4'd1,1'b1);
    vt[9]  = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b1,3'd3,8'h2A,1'b1, 1'b1,8'hB0,8'h01,8'h02,4'd2,1'b1);
    vt[10] = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b0,3'd0,8'h00,1'b1, 1'b1,8'hA0,8'h2A,8'h0B,4'd1,1'b1);
    vt[11] = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b0,3'd0,8'h00,1'b0, 1'b0,8'h00,8'h00,8'h00,4'd0,1'b1);
    vt[12] = mk(1'b1,8'hC0,3'd2,3'd6,1'b0,1'b0,8'h00,8'h00, 1'b0,3'd0,8'h00,1'b1, 1'b0,8'h00,8'h00,8'h00,4'd0,1'b1);
    vt[13] = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b1,3'd6,8'h66,1'b1, 1'b0,8'h00,8'h00,8'h00,4'd1,1'b1);
    vt[14] = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b1,3'd2,8'h44,1'b1, 1'b0,8'h00,8'h00,8'h00,4'd1,1'b1);
    vt[15] = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b0,3'd0,8'h00,1'b1, 1'b1,8'hC0,8'h44,8'h66,4'd1,1'b1);
    vt[16] = mk(1'b1,8'hD0,3'd4,3'd4,1'b0,1'b0,8'h00,8'h00, 1'b0,3'd0,8'h00,1'b1, 1'b0,8'h00,8'h00,8'h00,4'd0,1'b1);
    vt[17] = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b1,3'd4,8'h99,1'b1, 1'b0,8'h00,8'h00,8'h00,4'd1,1'b1);
    vt[18] = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b0,3'd0,8'h00,1'b1, 1'b1,8'hD0,8'h99,8'h99,4'd1,1'b1);
    vt[19] = mk(1'b0,8'h00,3'd0,3'd0,1'b0,1'b0,8'h00,8'h00, 1'b0,3'd0,8'h00,1'b0, 1'b0,8'h00,8'h00,8'h00,4'd0,1'b1);

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("reset occ", 32'(occupancy), 32'd0);
    chk("reset iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("reset iss_instr", 32'(bus.iss_instr), 32'd0);
    chk("reset disp_ready", 32'(bus.disp_ready), 32'd1);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);

    for (int k = 0; k < 20; k++) begin
      @(negedge clk); idle();
      if (vt[k].dv) disp(vt[k].instr, vt[k].t1, vt[k].t2, vt[k].r1, vt[k].r2, vt[k].v1, vt[k].v2);
      if (vt[k].cv) cdb(vt[k].ct, vt[k].cd);
      bus.iss_ready = vt[k].ir;
      #1;
      chk($sformatf("v%0d iss_valid", k), 32'(bus.iss_valid), 32'(vt[k].e_iv));
      chk($sformatf("v%0d iss_instr", k), 32'(bus.iss_instr), 32'(vt[k].e_in));
      chk($sformatf("v%0d iss_rd1", k), 32'(bus.iss_rd1), 32'(vt[k].e_r1));
      chk($sformatf("v%0d iss_rd2", k), 32'(bus.iss_rd2), 32'(vt[k].e_r2));
      chk($sformatf("v%0d occ", k), 32'(occupancy), 32'(vt[k].e_occ));
      chk($sformatf("v%0d disp_ready", k), 32'(bus.disp_ready), 32'(vt[k].e_dr));
    end

    // Fill with unready entries, reject a fifth, then wake the third one.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle();
      disp(8'(8'hE0 + i), 3'(i), 3'd0, 1'b0, 1'b1, 8'h00, 8'(i)); #1;
      chk($sformatf("fill%0d occ", i), 32'(occupancy), 32'(i));
    end
    @(negedge clk); idle(); disp(8'hE4, 3'd0, 3'd0, 1'b1, 1'b1, 8'h44, 8'h44); #1;
    chk("full disp_ready", 32'(bus.disp_ready), 32'd0);
    chk("full occ", 32'(occupancy), 32'd4);
    @(negedge clk); idle(); cdb(3'd2, 8'h55); bus.iss_ready = 1'b1; #1;
    chk("full5 ignored occ", 32'(occupancy), 32'd4);
    chk("full no bypass", 32'(bus.iss_valid), 32'd0);
    @(negedge clk); idle(); disp(8'hE5, 3'd0, 3'd0, 1'b1, 1'b1, 8'h00, 8'h00); bus.iss_ready = 1'b1; #1;
    chk("wake2 iss_instr", 32'(bus.iss_instr), 32'hE2);
    chk("wake2 iss_rd1", 32'(bus.iss_rd1), 32'h55);
    chk("full+issue disp_ready", 32'(bus.disp_ready), 32'd0);
    @(negedge clk); idle(); cdb(3'd3, 8'h63); #1;
    chk("after issue occ", 32'(occupancy), 32'd3);
    chk("after issue iss_valid", 32'(bus.iss_valid), 32'd0);
    @(negedge clk); idle(); cdb(3'd1, 8'h61); #1;
    chk("hold young iss_instr", 32'(bus.iss_instr), 32'hE3);
    @(negedge clk); idle(); cdb(3'd0, 8'h60); #1;
    chk("older priority iss_instr", 32'(bus.iss_instr), 32'hE1);
    sb.push_back('{8'hE0, 8'h60, 8'h00});
    sb.push_back('{8'hE1, 8'h61, 8'h01});
    sb.push_back('{8'hE3, 8'h63, 8'h03});
    drain("order");

    // Reset while an issuable entry is waiting and another is being dispatched.
    @(negedge clk); idle(); disp(8'hE8, 3'd0, 3'd0, 1'b1, 1'b1, 8'h01, 8'h01); #1;
    @(negedge clk); idle(); rst = 1'b1; bus.iss_ready = 1'b1;
    disp(8'hE9, 3'd0, 3'd0, 1'b1, 1'b1, 8'h02, 8'h02); #1;
    @(negedge clk); idle(); rst = 1'b0; #1;
    exp_stall = 0;
    chk("midrst occ", 32'(occupancy), 32'd0);
    chk("midrst iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("midrst iss_instr", 32'(bus.iss_instr), 32'd0);
    chk("midrst disp_ready", 32'(bus.disp_ready), 32'd1);
    chk("midrst stall_cnt", 32'(stall_cnt), 32'd0);

    // Two ready entries refused for five cycles.
    @(negedge clk); idle(); disp(8'hF0, 3'd7, 3'd0, 1'b0, 1'b1, 8'h00, 8'h10); #1;
    @(negedge clk); idle(); disp(8'hF1, 3'd7, 3'd0, 1'b0, 1'b1, 8'h00, 8'h11); #1;
    @(negedge clk); idle(); cdb(3'd7, 8'h77); #1;
    chk("stall pre iss_valid", 32'(bus.iss_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle(); #1;
      chk($sformatf("stall%0d iss_valid", i), 32'(bus.iss_valid), 32'd1);
      chk($sformatf("stall%0d iss_instr", i), 32'(bus.iss_instr), 32'hF0);
      add_stall();
    end
    @(negedge clk); idle(); disp(8'hF2, 3'd0, 3'd0, 1'b1, 1'b1, 8'h12, 8'h12); #1;
    chk("stall5 stall_cnt", 32'(stall_cnt), 32'(exp_sc()));
    chk("stall5 occ", 32'(occupancy), 32'd2);
    add_stall();

    // Flush with dispatch and wakeup in the same cycle.
    @(negedge clk); idle(); flush = 1'b1; bus.iss_ready = 1'b1;
    disp(8'hF3, 3'd0, 3'd0, 1'b1, 1'b1, 8'h13, 8'h13); cdb(3'd7, 8'h88); #1;
    chk("flush occ_before", 32'(occupancy), 32'd3);
    chk("flush iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("flush disp_ready", 32'(bus.disp_ready), 32'd0);
    @(negedge clk); idle(); bus.iss_ready = 1'b1; #1;
    chk("postflush occ", 32'(occupancy), 32'd0);
    chk("postflush iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("postflush stall_cnt", 32'(stall_cnt), 32'(exp_sc()));
    @(negedge clk); idle(); #1;
    chk("postflush2 occ", 32'(occupancy), 32'd0);

    // Random stream of ready instructions checked against the scoreboard.
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); idle();
      dv  = ($urandom_range(0, 3) != 0);
      ir  = ($urandom_range(0, 2) != 0);
      ins = 8'($urandom_range(0, 255));
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      if (dv) disp(ins, 3'd0, 3'd0, 1'b1, 1'b1, a, b);
      bus.iss_ready = ir;
      #1;
      sz = sb.size();
      chk($sformatf("s%0d occ", c), 32'(occupancy), 32'(sz));
      chk($sformatf("s%0d iss_valid", c), 32'(bus.iss_valid), 32'(sz != 0));
      chk($sformatf("s%0d disp_ready", c), 32'(bus.disp_ready), 32'(sz < DEPTH));
      if (sz != 0) begin
        chk($sformatf("s%0d iss_instr", c), 32'(bus.iss_instr), 32'(sb[0].instr));
        chk($sformatf("s%0d iss_rd1", c), 32'(bus.iss_rd1), 32'(sb[0].rd1));
        chk($sformatf("s%0d iss_rd2", c), 32'(bus.iss_rd2), 32'(sb[0].rd2));
        if (ir) void'(sb.pop_front());
        else add_stall();
      end
      if (dv && sz < DEPTH) sb.push_back('{ins, a, b});
    end
    drain("stream");
    chk("stream stall_cnt", 32'(stall_cnt), 32'(exp_sc()));

    // Long refusal to exercise counter saturation.
    @(negedge clk); idle(); disp(8'h5A, 3'd0, 3'd0, 1'b1, 1'b1, 8'hA5, 8'h5A); #1;
    sb.push_back('{8'h5A, 8'hA5, 8'h5A});
    for (int i = 0; i < 260; i++) begin
      @(negedge clk); idle(); #1;
      add_stall();
    end
    chk("sat stall_cnt", 32'(stall_cnt), 32'(exp_sc()));
    drain("sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
